rbi_ring_initiator: RTL and testbench

- Ringbus initiator node: the requester end of the L2/ROM/MMIO ring.
- Accepts L1-side memory requests over a valid/ready interface and injects them into empty ring slots, tagging each with a node ID and sequence number.
- Captures responses addressed to this node and returns them to the client. All other ring traffic passes through with one cycle of latency.

---
 rtl/rbi_ring_initiator.sv | 168 ++++++++++++++++
 tb/tb_rbi_ring_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rbi_ring_initiator.sv
// Ringbus initiator node: injects client requests into empty slots,
// captures own responses, retires timed-out tags, forwards all else.
module rbi_ring_initiator #(
  parameter int MAX_OUT      = 4,
  parameter int RESP_TIMEOUT = 4095
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [15:0]  memSeqIn,
  input  logic [15:0]  memOpmIn,
  input  logic [47:0]  memAddrIn,
  input  logic [127:0] memDataIn,
  output logic [15:0]  memSeqOut,
  output logic [15:0]  memOpmOut,
  output logic [47:0]  memAddrOut,
  output logic [127:0] memDataOut,
  input  logic [7:0]   unitNodeId,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic [15:0]  reqOpm,
  input  logic [47:0]  reqAddr,
  input  logic [127:0] reqData,
  output logic         rspValid,
  input  logic         rspReady,
  output logic [15:0]  rspOpm,
  output logic [47:0]  rspAddr,
  output logic [127:0] rspData,
  output logic         rspErr,
  output logic [3:0]   outCount
);
  localparam int IW = 3;
  localparam logic [11:0] RT = 12'(RESP_TIMEOUT);

  logic [15:0]  so_q, so_d, oo_q, oo_d;
  logic [47:0]  ao_q, ao_d;
  logic [127:0] do_q, do_d;
  logic         hv_q, hv_d;
  logic [15:0]  hopm_q, hopm_d;
  logic [47:0]  haddr_q, haddr_d;
  logic [127:0] hdata_q, hdata_d;
  logic [7:0]   ctr_q, ctr_d;
  logic         tv_q [MAX_OUT];
  logic         tv_d [MAX_OUT];
  logic [7:0]   tseq_q [MAX_OUT];
  logic [7:0]   tseq_d [MAX_OUT];
  logic [11:0]  ttmr_q [MAX_OUT];
  logic [11:0]  ttmr_d [MAX_OUT];
  logic [15:0]  topm_q [MAX_OUT];
  logic [15:0]  topm_d [MAX_OUT];
  logic [47:0]  taddr_q [MAX_OUT];
  logic [47:0]  taddr_d [MAX_OUT];
  logic         rv_q, rv_d, rerr_q, rerr_d;
  logic [15:0]  ropm_q, ropm_d;
  logic [47:0]  raddr_q, raddr_d;
  logic [127:0] rdata_q, rdata_d;

  logic          hit, cap, to_hit, ret, free_ok, conflict, inj, buf_free;
  logic [IW-1:0] hit_idx, to_idx, free_idx;
  logic [3:0]    cnt;

  // Count of live tags
  always_comb begin
    cnt = '0;
    for (int i = 0; i < MAX_OUT; i++) cnt = cnt + 4'(tv_q[i]);
  end

  // Slot decision: capture, else inject, else forward; plus timeouts
  always_comb begin
    so_d = memSeqIn; oo_d = memOpmIn;
    ao_d = memAddrIn; do_d = memDataIn;
    hv_d = hv_q; hopm_d = hopm_q;
    haddr_d = haddr_q; hdata_d = hdata_q;
    ctr_d = ctr_q;
    tv_d = tv_q; tseq_d = tseq_q; ttmr_d = ttmr_q;
    topm_d = topm_q; taddr_d = taddr_q;
    rv_d = rv_q; rerr_d = rerr_q; ropm_d = ropm_q;
    raddr_d = raddr_q; rdata_d = rdata_q;
    hit = 1'b0; hit_idx = '0;
    to_hit = 1'b0; to_idx = '0;
    free_ok = 1'b0; free_idx = '0;
    conflict = 1'b0;

    buf_free = !rv_q || rspReady;
    for (int i = 0; i < MAX_OUT; i++)
      if (!hit && tv_q[i] && tseq_q[i] == memSeqIn[7:0]) begin
        hit = 1'b1; hit_idx = IW'(i);
      end
    cap = memOpmIn[7:6] == 2'b01 && memSeqIn[15:8] == unitNodeId
          && hit && buf_free;

    for (int i = 0; i < MAX_OUT; i++) begin
      if (!to_hit && tv_q[i] && ttmr_q[i] == RT) begin
        to_hit = 1'b1; to_idx = IW'(i);
      end
      if (!free_ok && (!tv_q[i] || (cap && hit_idx == IW'(i)))) begin
        free_ok = 1'b1; free_idx = IW'(i);
      end
      if (tv_q[i] && !(cap && hit_idx == IW'(i)) && tseq_q[i] == ctr_q)
        conflict = 1'b1;
      if (tv_q[i] && ttmr_q[i] != RT) ttmr_d[i] = ttmr_q[i] + 12'd1;
    end
    ret = to_hit && buf_free && !cap;
    inj = (memOpmIn[7:0] == 8'h00 || cap) && hv_q && free_ok && !conflict;

    if (rv_q && rspReady) rv_d = 1'b0;
    if (ret) begin
      tv_d[to_idx] = 1'b0;
      rv_d = 1'b1; rerr_d = 1'b1;
      ropm_d = topm_q[to_idx]; raddr_d = taddr_q[to_idx];
      rdata_d = '0;
    end
    if (cap) begin
      tv_d[hit_idx] = 1'b0;
      rv_d = 1'b1; rerr_d = 1'b0;
      ropm_d = memOpmIn; raddr_d = memAddrIn; rdata_d = memDataIn;
      so_d = '0; oo_d = '0; ao_d = '0; do_d = '0;
    end
    if (inj) begin
      so_d = {unitNodeId, ctr_q}; oo_d = hopm_q;
      ao_d = haddr_q; do_d = hdata_q;
      tv_d[free_idx] = 1'b1; tseq_d[free_idx] = ctr_q;
      ttmr_d[free_idx] = '0; topm_d[free_idx] = hopm_q;
      taddr_d[free_idx] = haddr_q;
      ctr_d = (ctr_q == 8'hFF) ? 8'h01 : ctr_q + 8'h01;
      hv_d = 1'b0;
    end
    if (reqValid && !hv_q) begin
      hv_d = 1'b1; hopm_d = reqOpm;
      haddr_d = reqAddr; hdata_d = reqData;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      so_q <= '0; oo_q <= '0; ao_q <= '0; do_q <= '0;
      hv_q <= 1'b0; hopm_q <= '0; haddr_q <= '0; hdata_q <= '0;
      ctr_q <= 8'h01;
      for (int i = 0; i < MAX_OUT; i++) begin
        tv_q[i] <= 1'b0; tseq_q[i] <= '0; ttmr_q[i] <= '0;
        topm_q[i] <= '0; taddr_q[i] <= '0;
      end
      rv_q <= 1'b0; rerr_q <= 1'b0; ropm_q <= '0;
      raddr_q <= '0; rdata_q <= '0;
    end else begin
      so_q <= so_d; oo_q <= oo_d; ao_q <= ao_d; do_q <= do_d;
      hv_q <= hv_d; hopm_q <= hopm_d;
      haddr_q <= haddr_d; hdata_q <= hdata_d;
      ctr_q <= ctr_d;
      tv_q <= tv_d; tseq_q <= tseq_d; ttmr_q <= ttmr_d;
      topm_q <= topm_d; taddr_q <= taddr_d;
      rv_q <= rv_d; rerr_q <= rerr_d; ropm_q <= ropm_d;
      raddr_q <= raddr_d; rdata_q <= rdata_d;
    end
  end

  assign memSeqOut  = so_q;
  assign memOpmOut  = oo_q;
  assign memAddrOut = ao_q;
  assign memDataOut = do_q;
  assign reqReady   = !hv_q;
  assign rspValid   = rv_q;
  assign rspOpm     = ropm_q;
  assign rspAddr    = raddr_q;
  assign rspData    = rdata_q;
  assign rspErr     = rerr_q;
  assign outCount   = cnt;
endmodule

// File: tb/tb_rbi_ring_initiator.sv
// Directed bench for rbi_ring_initiator: inject, capture,
// back-pressure, recirculation, reset discard and timeout.
module tb_rbi_ring_initiator;
  logic         clock = 1'b0;
  logic         reset;
  logic [15:0]  memSeqIn, memOpmIn, memSeqOut, memOpmOut;
  logic [47:0]  memAddrIn, memAddrOut;
  logic [127:0] memDataIn, memDataOut;
  logic [7:0]   unitNodeId;
  logic         reqValid, reqReady;
  logic [15:0]  reqOpm, rspOpm;
  logic [47:0]  reqAddr, rspAddr;
  logic [127:0] reqData, rspData;
  logic         rspValid, rspReady, rspErr;
  logic [3:0]   outCount;
  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clock = ~clock;

  rbi_ring_initiator #(.MAX_OUT(4), .RESP_TIMEOUT(4095)) dut (
    .clock(clock), .reset(reset),
    .memSeqIn(memSeqIn), .memOpmIn(memOpmIn),
    .memAddrIn(memAddrIn), .memDataIn(memDataIn),
    .memSeqOut(memSeqOut), .memOpmOut(memOpmOut),
    .memAddrOut(memAddrOut), .memDataOut(memDataOut),
    .unitNodeId(unitNodeId),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOpm(reqOpm), .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspOpm(rspOpm), .rspAddr(rspAddr), .rspData(rspData),
    .rspErr(rspErr), .outCount(outCount)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ring(input logic [15:0] s, input logic [15:0] o,
                      input logic [47:0] a, input logic [127:0] d);
    memSeqIn = s; memOpmIn = o; memAddrIn = a; memDataIn = d;
  endtask

  task automatic issue(input logic [15:0] o, input logic [47:0] a);
    reqValid = 1'b1; reqOpm = o; reqAddr = a;
    step();
    reqValid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    reqValid = 1'b0; rspReady = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    unitNodeId = 8'h12;
    reqOpm = 16'h0; reqAddr = 48'h0; reqData = 128'h0;
    do_reset();
    chk("rst_opm", 128'(memOpmOut), 128'h0);
    chk("rst_seq", 128'(memSeqOut), 128'h0);
    chk("rst_rdy", 128'(reqReady), 128'h1);
    chk("rst_rv", 128'(rspValid), 128'h0);
    chk("rst_cnt", 128'(outCount), 128'h0);

    // first request into empty ring
    issue(16'h0093, 48'h1000);
    chk("inj_seq", 128'(memSeqOut), 128'h1201);
    chk("inj_opm", 128'(memOpmOut), 128'h0093);
    chk("inj_addr", 128'(memAddrOut), 128'h1000);
    chk("inj_cnt", 128'(outCount), 128'h1);

    // its response
    ring(16'h1201, 16'h0040, 48'h0, 128'hA5);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("cap_rv", 128'(rspValid), 128'h1);
    chk("cap_data", rspData, 128'hA5);
    chk("cap_err", 128'(rspErr), 128'h0);
    chk("cap_slot", 128'(memOpmOut[7:0]), 128'h0);
    chk("cap_cnt", 128'(outCount), 128'h0);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    chk("drain_rv", 128'(rspValid), 128'h0);

    // occupied slots forward; inject on first empty
    ring(16'h3407, 16'h0011, 48'h55, 128'h77);
    reqValid = 1'b1; reqOpm = 16'h0093; reqAddr = 48'h2000;
    step();
    reqValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("fwd_seq", 128'(memSeqOut), 128'h3407);
      chk("fwd_opm", 128'(memOpmOut), 128'h0011);
      chk("fwd_data", memDataOut, 128'h77);
      if (i < 4) step();
    end
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    step();
    chk("late_seq", 128'(memSeqOut), 128'h1202);
    chk("late_addr", 128'(memAddrOut), 128'h2000);

    // reset discards tag 2; its response is then stale
    do_reset();
    chk("mrst_cnt", 128'(outCount), 128'h0);
    ring(16'h1202, 16'h0040, 48'h9, 128'hEE);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("stale_seq", 128'(memSeqOut), 128'h1202);
    chk("stale_opm", 128'(memOpmOut), 128'h0040);
    chk("stale_rv", 128'(rspValid), 128'h0);

    // fill to MAX_OUT
    for (int i = 0; i < 4; i++) issue(16'h0083, 48'(i + 16'h100));
    chk("full_cnt", 128'(outCount), 128'h4);
    reqValid = 1'b1; reqAddr = 48'h500;
    step();
    reqValid = 1'b0;
    step(); step();
    chk("full_opm", 128'(memOpmOut), 128'h0);
    chk("full_rdy", 128'(reqReady), 128'h0);
    chk("full_cnt2", 128'(outCount), 128'h4);

    // capture tag 2 and reuse slot
    ring(16'h1202, 16'h0040, 48'h101, 128'h22);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("ci_seq", 128'(memSeqOut), 128'h1205);
    chk("ci_opm", 128'(memOpmOut), 128'h0083);
    chk("ci_addr", 128'(memAddrOut), 128'h500);
    chk("ci_data", rspData, 128'h22);
    chk("ci_cnt", 128'(outCount), 128'h4);
    chk("ci_rdy", 128'(reqReady), 128'h1);

    // buffer full: response for tag 1 recirculates
    ring(16'h1201, 16'h0040, 48'h100, 128'h11);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("bp_seq", 128'(memSeqOut), 128'h1201);
    chk("bp_opm", 128'(memOpmOut), 128'h0040);
    chk("bp_data", memDataOut, 128'h11);
    chk("bp_hold", rspData, 128'h22);
    chk("bp_cnt", 128'(outCount), 128'h4);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    chk("bp_drain", 128'(rspValid), 128'h0);
    ring(16'h1201, 16'h0040, 48'h100, 128'h11);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("rc_data", rspData, 128'h11);
    chk("rc_addr", 128'(rspAddr), 128'h100);
    chk("rc_cnt", 128'(outCount), 128'h3);

    // capture while draining refills the buffer
    rspReady = 1'b1;
    ring(16'h1203, 16'h0040, 48'h102, 128'h33);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("cd_rv", 128'(rspValid), 128'h1);
    chk("cd_data", rspData, 128'h33);
    chk("cd_cnt", 128'(outCount), 128'h2);
    step();
    rspReady = 1'b0;
    chk("cd_drain", 128'(rspValid), 128'h0);

    // timeout retirement
    do_reset();
    issue(16'h0093, 48'hABC);
    chk("to_cnt0", 128'(outCount), 128'h1);
    lat = 0;
    while (!rspValid && lat < 5000) begin
      step();
      lat++;
    end
    chk("to_seen", 128'(rspValid), 128'h1);
    chk("to_lat", 128'(lat >= 4094 && lat <= 4098), 128'h1);
    chk("to_err", 128'(rspErr), 128'h1);
    chk("to_addr", 128'(rspAddr), 128'hABC);
    chk("to_opm", 128'(rspOpm), 128'h0093);
    chk("to_data", rspData, 128'h0);
    chk("to_cnt", 128'(outCount), 128'h0);
    step();
    chk("to_hold", 128'(rspErr & rspValid), 128'h1);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    ring(16'h1201, 16'h0040, 48'hABC, 128'h5);
    step();
    ring(16'h0, 16'h0, 48'h0, 128'h0);
    chk("tos_seq", 128'(memSeqOut), 128'h1201);
    chk("tos_opm", 128'(memOpmOut), 128'h0040);
    chk("tos_rv", 128'(rspValid), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
